// File: rtl/decode_timeout_mclks_if.sv
// Handshake and data bundle between a decode requester and decode_timeout_mclks.
// The requester drives start and the captured operands; the decoder returns
// status and the result.
interface decode_timeout_mclks_if;
    logic        start;
    logic [15:0] encoded_timeout;
    logic [15:0] pre_range_mclks;
    logic        subtract_pre_range;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] timeout_mclks;

    modport master (
        output start, encoded_timeout, pre_range_mclks, subtract_pre_range,
        input  busy, done, overflow, timeout_mclks
    );

    modport slave (
        input  start, encoded_timeout, pre_range_mclks, subtract_pre_range,
        output busy, done, overflow, timeout_mclks
    );
endinterface

// File: rtl/decode_timeout_mclks.sv
// Iterative decoder for VL53L0X-style encoded timeouts: (LSB << MSB) + 1.
// Optional feature macro: DECODE_PRE_RANGE_SUB_EN builds the pre-range
// subtraction (clamped at zero) used for the final-range step.
//
// state    | meaning
// S_IDLE   | waiting for start, operands captured on the start edge
// S_LOAD   | load accumulator with LSB and shift count with min(MSB, cap)
// S_SHIFT  | one left shift per cycle until the count is used up
// S_ADJUST | add one, optional pre-range subtract, saturate, register result
// S_DONE   | one-cycle done pulse
module decode_timeout_mclks #(
    parameter int unsigned SHIFT_CAP = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    decode_timeout_mclks_if.slave  bus
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_ADJUST, S_DONE} state_t;

    localparam logic [7:0] CAP8 = 8'(SHIFT_CAP);

    state_t      state, state_nxt;
    logic [7:0]  lsb_q, msb_q, cnt_q;
    logic [23:0] acc_q;
    logic [15:0] timeout_q;
    logic        overflow_q;
    logic [7:0]  cnt_load;
    logic        sat;
    logic signed [24:0] v_res;
    logic [15:0] res_val;
    logic        res_ovf;
    logic        busy_c, done_c;

`ifdef DECODE_PRE_RANGE_SUB_EN
    logic [15:0] pre_q;
    logic        sub_q;
`else
    logic unused_pre_range;
    assign unused_pre_range = ^{bus.pre_range_mclks, bus.subtract_pre_range};
`endif

    assign cnt_load = (msb_q >= CAP8) ? CAP8 : msb_q;
    assign sat      = (msb_q >= CAP8) && (lsb_q != 8'd0);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; start is only honoured in S_IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.start) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = (cnt_load != 8'd0) ? S_SHIFT : S_ADJUST;
            S_SHIFT:  if (cnt_q == 8'd1) state_nxt = S_ADJUST;
            S_ADJUST: state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        case (state)
            S_LOAD, S_SHIFT, S_ADJUST: busy_c = 1'b1;
            S_DONE:                    done_c = 1'b1;
            default: ;
        endcase
    end

    // Result: 25-bit signed so the subtract can go negative before clamping.
    always_comb begin
        v_res = $signed({1'b0, acc_q}) + 25'sd1;
`ifdef DECODE_PRE_RANGE_SUB_EN
        if (sub_q) begin
            v_res = v_res - $signed({9'b0, pre_q});
            if (v_res < 25'sd0) v_res = 25'sd0;
        end
`endif
        res_ovf = sat || (v_res > 25'sd65535);
        res_val = res_ovf ? 16'hFFFF : v_res[15:0];
    end

    // Operand capture, shift datapath and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lsb_q      <= '0;
            msb_q      <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            timeout_q  <= '0;
            overflow_q <= 1'b0;
`ifdef DECODE_PRE_RANGE_SUB_EN
            pre_q      <= '0;
            sub_q      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    lsb_q      <= bus.encoded_timeout[7:0];
                    msb_q      <= bus.encoded_timeout[15:8];
                    overflow_q <= 1'b0;
`ifdef DECODE_PRE_RANGE_SUB_EN
                    pre_q      <= bus.pre_range_mclks;
                    sub_q      <= bus.subtract_pre_range;
`endif
                end
                S_LOAD: begin
                    acc_q <= {16'b0, lsb_q};
                    cnt_q <= cnt_load;
                end
                S_SHIFT: begin
                    acc_q <= acc_q << 1;
                    cnt_q <= cnt_q - 8'd1;
                end
                S_ADJUST: begin
                    timeout_q  <= res_val;
                    overflow_q <= res_ovf;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy          = busy_c;
    assign bus.done          = done_c;
    assign bus.overflow      = overflow_q;
    assign bus.timeout_mclks = timeout_q;

endmodule

// File: doc/decode_timeout_mclks.md
# decode_timeout_mclks

Decodes a VL53L0X-format encoded sequence-step timeout register value into a plain macro-clock count. An encoded word has value (LSB << MSB) + 1, where LSB is bits [7:0] and MSB is bits [15:8]. Sits directly upstream of the mclks-to-microseconds converter in the sensor module; its `timeout_mclks` output drives that stage's `timeout_period_mclks` input. A start/done handshake matches the downstream stage, and the shift is iterative to keep the logic small.

## Interface
- `SHIFT_CAP`, default 16: maximum number of shift cycles. Any encoded MSB at or above this value with a nonzero LSB saturates.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs immediately.
- `start`  in  1  request a decode; sampled only in S_IDLE.
- `encoded_timeout`  in  16  encoded register value; captured on the start edge.
- `pre_range_mclks`  in  16  pre-range timeout in mclks; captured on the start edge (used only with the macro).
- `subtract_pre_range`  in  1  pre-range step enabled; captured on the start edge (used only with the macro).
- `busy`  out  1  high from the start edge until the edge that sets `done`.
- `done`  out  1  one-cycle pulse; result valid.
- `overflow`  out  1  result saturated; valid with `done`, held until the next start.
- `timeout_mclks`  out  16  decoded (and optionally adjusted) mclks; held until the next result.

## Operation
- States:
  - S_IDLE: on `start`, capture the inputs, set `busy`, clear `overflow`, go to S_LOAD.
  - S_LOAD: acc = {16'b0, LSB} (24-bit); cnt = min(MSB, SHIFT_CAP). Go to S_SHIFT if cnt ≠ 0, else S_ADJUST.
  - S_SHIFT: each cycle acc <<= 1 and cnt -= 1. Go to S_ADJUST when cnt reaches 1 on entry.
  - S_ADJUST: compute the result (below). Register `timeout_mclks` and `overflow`, set `done` = 1, clear `busy`, go to S_DONE.
  - S_DONE: clear `done`, go to S_IDLE.
- Result computation, all in a 25-bit signed intermediate:
  - v = acc + 1.
  - Saturation flag sat = (MSB ≥ SHIFT_CAP && LSB ≠ 0).
  - With the macro and captured `subtract_pre_range` = 1: v = v − pre_range_mclks. If v < 0, v = 0.
  - If sat, or v > 16'hFFFF: `timeout_mclks` = 16'hFFFF and `overflow` = 1.
  - Otherwise `timeout_mclks` = v[15:0].
- LSB = 0 decodes to 1, whatever the MSB; this case never saturates.
- `start` in any state other than S_IDLE is ignored. No queuing.
- Inputs may change after the start edge without affecting the result.
- Reset mid-operation: return to S_IDLE. `busy`, `done` and `overflow` go to 0, `timeout_mclks` goes to 0. No `done` is issued for the aborted request.

## Timing
- Reset values: `busy` 0, `done` 0, `overflow` 0, `timeout_mclks` 16'h0000, state S_IDLE.
- `start` sampled at edge k. `done` rises at edge k+2+S and falls at edge k+3+S, where S = min(MSB, SHIFT_CAP).
- Latency is 2 cycles minimum (MSB = 0) and 18 cycles maximum with the default parameter.
- `timeout_mclks` and `overflow` change only on the S_ADJUST edge or on reset.
- The earliest accepted back-to-back start is the cycle after `done`, i.e. the S_IDLE cycle at edge k+3+S.

## Configuration
- `DECODE_PRE_RANGE_SUB_EN` defined:
  - The final-range adjustment is compiled in.
  - When captured `subtract_pre_range` = 1, `pre_range_mclks` is subtracted, clamping at 0.
- `DECODE_PRE_RANGE_SUB_EN` undefined:
  - No subtractor is built.
  - `pre_range_mclks` and `subtract_pre_range` are ignored, and the result is always the pure decode.
  - Timing is identical in both builds.

## Test plan
- Decode with MSB = 0: reset, then start with 16'h0000 → `done` at start edge +2, `timeout_mclks` = 1, `overflow` = 0.
- Nominal decode: start with 16'h0305 → `done` at start edge +5, `timeout_mclks` = 41, `busy` high for 5 cycles.
- Saturation: start with 16'h10FF → `done` at start edge +18, `timeout_mclks` = 16'hFFFF, `overflow` = 1. Also start with 16'h0A00 → `timeout_mclks` = 1, `overflow` = 0.
- Pre-range subtraction (macro on):
  - 16'h0480 with pre = 100 → 1949.
  - 16'h0203 with pre = 20 → 0 (clamp).
  - 16'h0480 with `subtract_pre_range` = 0 → 2049.
- Pre-range inputs ignored (macro off): same stimulus → 2049 and 13, regardless of `pre_range_mclks`.
- Handshake and reset:
  - Pulse `start` with 16'h0001 during the S_SHIFT cycles of a 16'h0305 decode → only one `done`, value 41.
  - Assert `reset` mid-shift → outputs 0 immediately and no `done`. The next start decodes correctly.
